// File: rtl/axis_byte_word_bridge.sv
// ============================================================================
// axis_byte_word_bridge
//
// Byte <-> 16-bit word adapter between a serial byte stream (UART side) and
// the 16-bit command/response streams of the AXI-Lite command master.
//
//   RX path: s_axis_byte -> pack two bytes (high byte first) -> m_axis_word
//   TX path: s_axis_word -> split into two bytes (high byte first) -> m_axis_byte
//
// Both paths are registered and sustain one byte per cycle. They are
// completely independent of each other.
//
// Ports:
//   aclk, areset            clock (rising edge), async active-high reset
//   s_axis_byte_*           RX byte input  (tdata[7:0], tvalid, tready)
//   m_axis_word_*           packed word output (tdata[15:0], tvalid, tready)
//   s_axis_word_*           response word input (tdata[15:0], tvalid, tready)
//   m_axis_byte_*           TX byte output (tdata[7:0], tvalid, tready)
//   rx_timeout              one-cycle pulse when a dangling high byte is dropped
//
// Build option:
//   AXIS_BYTE_WORD_BRIDGE_TIMEOUT_EN - when defined, a half-word left waiting
//   in R_HALF for TIMEOUT_CYCLES cycles is discarded so pairing realigns.
//   When undefined no counter exists and rx_timeout is tied low.
//
// RX FSM
//   state  | meaning
//   R_IDLE | no byte held
//   R_HALF | high byte held, waiting for low byte
//   R_FULL | word presented on m_axis_word
//
// TX FSM
//   state   | meaning
//   T_EMPTY | no word held
//   T_HI    | presenting high byte of stored word
//   T_LO    | presenting low byte; may accept the next word
// ============================================================================
module axis_byte_word_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic        aclk,
    input  logic        areset,

    input  logic [7:0]  s_axis_byte_tdata,
    input  logic        s_axis_byte_tvalid,
    output logic        s_axis_byte_tready,

    output logic [15:0] m_axis_word_tdata,
    output logic        m_axis_word_tvalid,
    input  logic        m_axis_word_tready,

    input  logic [15:0] s_axis_word_tdata,
    input  logic        s_axis_word_tvalid,
    output logic        s_axis_word_tready,

    output logic [7:0]  m_axis_byte_tdata,
    output logic        m_axis_byte_tvalid,
    input  logic        m_axis_byte_tready,

    output logic        rx_timeout
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 2..65535");
    end

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {R_IDLE, R_HALF, R_FULL} rx_state_t;

    rx_state_t  rx_state, rx_state_nxt;
    logic [7:0] rx_hi;
    logic       rx_byte_hs;
    logic       rx_word_hs;
    logic       rx_expire;

    assign rx_byte_hs = s_axis_byte_tvalid && s_axis_byte_tready;
    assign rx_word_hs = m_axis_word_tvalid && m_axis_word_tready;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) rx_state <= R_IDLE;
        else        rx_state <= rx_state_nxt;
    end

    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            R_IDLE: if (rx_byte_hs) rx_state_nxt = R_HALF;
            R_HALF: begin
                if (rx_byte_hs)     rx_state_nxt = R_FULL;
                else if (rx_expire) rx_state_nxt = R_IDLE;
            end
            R_FULL: begin
                // A byte can only be accepted here on the cycle the word leaves.
                if (rx_word_hs) rx_state_nxt = rx_byte_hs ? R_HALF : R_IDLE;
            end
            default: rx_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        s_axis_byte_tready = 1'b0;
        if (!areset) begin
            case (rx_state)
                R_IDLE, R_HALF: s_axis_byte_tready = 1'b1;
                R_FULL:         s_axis_byte_tready = m_axis_word_tready;
                default:        s_axis_byte_tready = 1'b0;
            endcase
        end
        m_axis_word_tvalid = (rx_state == R_FULL);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rx_hi             <= 8'h00;
            m_axis_word_tdata <= 16'h0000;
        end else if (rx_byte_hs) begin
            if (rx_state == R_HALF) m_axis_word_tdata <= {rx_hi, s_axis_byte_tdata};
            else                    rx_hi             <= s_axis_byte_tdata;
        end
    end

`ifdef AXIS_BYTE_WORD_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] RX_CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] rx_cnt;

    // A byte arriving on the terminal cycle completes the word instead.
    assign rx_expire = (rx_state == R_HALF) && (rx_cnt == RX_CNT_LAST) && !rx_byte_hs;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rx_cnt     <= 16'h0000;
            rx_timeout <= 1'b0;
        end else begin
            rx_timeout <= rx_expire;
            if (rx_state == R_HALF && !rx_byte_hs && !rx_expire) rx_cnt <= rx_cnt + 16'd1;
            else                                                 rx_cnt <= 16'h0000;
        end
    end
`else
    assign rx_expire  = 1'b0;
    assign rx_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {T_EMPTY, T_HI, T_LO} tx_state_t;

    tx_state_t  tx_state, tx_state_nxt;
    logic [7:0] tx_lo;
    logic       tx_word_hs;
    logic       tx_byte_hs;

    assign tx_word_hs = s_axis_word_tvalid && s_axis_word_tready;
    assign tx_byte_hs = m_axis_byte_tvalid && m_axis_byte_tready;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) tx_state <= T_EMPTY;
        else        tx_state <= tx_state_nxt;
    end

    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            T_EMPTY: if (tx_word_hs) tx_state_nxt = T_HI;
            T_HI:    if (tx_byte_hs) tx_state_nxt = T_LO;
            T_LO:    if (tx_byte_hs) tx_state_nxt = tx_word_hs ? T_HI : T_EMPTY;
            default: tx_state_nxt = T_EMPTY;
        endcase
    end

    always_comb begin
        s_axis_word_tready = 1'b0;
        if (!areset) begin
            case (tx_state)
                T_EMPTY: s_axis_word_tready = 1'b1;
                T_LO:    s_axis_word_tready = m_axis_byte_tready;
                default: s_axis_word_tready = 1'b0;
            endcase
        end
        m_axis_byte_tvalid = (tx_state != T_EMPTY);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            tx_lo             <= 8'h00;
            m_axis_byte_tdata <= 8'h00;
        end else if (tx_word_hs) begin
            m_axis_byte_tdata <= s_axis_word_tdata[15:8];
            tx_lo             <= s_axis_word_tdata[7:0];
        end else if (tx_state == T_HI && tx_byte_hs) begin
            m_axis_byte_tdata <= tx_lo;
        end
    end

endmodule

// File: tb/tb_axis_byte_word_bridge.sv
module tb_axis_byte_word_bridge;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [7:0]  s_axis_byte_tdata = 8'h00;
    logic        s_axis_byte_tvalid = 1'b0;
    logic        s_axis_byte_tready;
    logic [15:0] m_axis_word_tdata;
    logic        m_axis_word_tvalid;
    logic        m_axis_word_tready = 1'b1;
    logic [15:0] s_axis_word_tdata = 16'h0000;
    logic        s_axis_word_tvalid = 1'b0;
    logic        s_axis_word_tready;
    logic [7:0]  m_axis_byte_tdata;
    logic        m_axis_byte_tvalid;
    logic        m_axis_byte_tready = 1'b1;
    logic        rx_timeout;

    axis_byte_word_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .aclk               (aclk),
        .areset             (areset),
        .s_axis_byte_tdata  (s_axis_byte_tdata),
        .s_axis_byte_tvalid (s_axis_byte_tvalid),
        .s_axis_byte_tready (s_axis_byte_tready),
        .m_axis_word_tdata  (m_axis_word_tdata),
        .m_axis_word_tvalid (m_axis_word_tvalid),
        .m_axis_word_tready (m_axis_word_tready),
        .s_axis_word_tdata  (s_axis_word_tdata),
        .s_axis_word_tvalid (s_axis_word_tvalid),
        .s_axis_word_tready (s_axis_word_tready),
        .m_axis_byte_tdata  (m_axis_byte_tdata),
        .m_axis_byte_tvalid (m_axis_byte_tvalid),
        .m_axis_byte_tready (m_axis_byte_tready),
        .rx_timeout         (rx_timeout)
    );

    always #5 aclk = ~aclk;

    int tests_run = 0;
    int fails = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    bit rand_en = 1'b0;

    logic [15:0] exp_words[$];
    logic [7:0]  exp_bytes[$];
    int          tx_hs_cyc[$];

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: handshakes complete at the following rising edge.
    always @(negedge aclk) begin
        if (!areset) begin
            if (m_axis_word_tvalid && m_axis_word_tready) begin
                if (exp_words.size() == 0) begin
                    tests_run++; fails++;
                    $display("FAIL rx_word_unexpected: got %0h expected none", m_axis_word_tdata);
                end else begin
                    check("rx_word", 32'(m_axis_word_tdata), 32'(exp_words.pop_front()));
                end
            end
            if (m_axis_byte_tvalid && m_axis_byte_tready) begin
                tx_hs_cyc.push_back(cyc);
                if (exp_bytes.size() == 0) begin
                    tests_run++; fails++;
                    $display("FAIL tx_byte_unexpected: got %0h expected none", m_axis_byte_tdata);
                end else begin
                    check("tx_byte", 32'(m_axis_byte_tdata), 32'(exp_bytes.pop_front()));
                end
            end
            if (rx_timeout) pulse_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        s_axis_byte_tdata  = b;
        s_axis_byte_tvalid = 1'b1;
        forever begin
            @(negedge aclk);
            if (s_axis_byte_tready) break;
            n++;
            if (n > 2000) begin
                tests_run++; fails++;
                $display("FAIL send_byte_stuck: got tready 0 expected 1 for byte %0h", b);
                break;
            end
        end
        @(posedge aclk); #1;
    endtask

    task automatic send_word(input logic [15:0] w);
        int n = 0;
        s_axis_word_tdata  = w;
        s_axis_word_tvalid = 1'b1;
        forever begin
            @(negedge aclk);
            if (s_axis_word_tready) break;
            n++;
            if (n > 2000) begin
                tests_run++; fails++;
                $display("FAIL send_word_stuck: got tready 0 expected 1 for word %0h", w);
                break;
            end
        end
        @(posedge aclk); #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_words.size() != 0 || exp_bytes.size() != 0) && n < 5000) begin
            @(posedge aclk); n++;
        end
        #1;
        check("rx_queue_drained", 32'(exp_words.size()), 32'd0);
        check("tx_queue_drained", 32'(exp_bytes.size()), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    int t0;
    int pulse_base;
    logic [7:0]  b0, b1;
    logic [15:0] w;

    initial begin
        // Reset: readies driven high to show tready is still forced low.
        @(negedge aclk);
        check("rst_s_byte_tready", 32'(s_axis_byte_tready), 32'd0);
        check("rst_s_word_tready", 32'(s_axis_word_tready), 32'd0);
        check("rst_word_tvalid",   32'(m_axis_word_tvalid), 32'd0);
        check("rst_byte_tvalid",   32'(m_axis_byte_tvalid), 32'd0);
        check("rst_word_tdata",    32'(m_axis_word_tdata),  32'd0);
        check("rst_byte_tdata",    32'(m_axis_byte_tdata),  32'd0);
        check("rst_rx_timeout",    32'(rx_timeout),         32'd0);
        @(posedge aclk); #1;
        areset = 1'b0;
        idle(2);
        check("idle_word_tvalid", 32'(m_axis_word_tvalid), 32'd0);

        // Back-to-back packing.
        exp_words.push_back(16'h1234);
        exp_words.push_back(16'h5678);
        t0 = cyc;
        send_byte(8'h12);
        send_byte(8'h34);
        check("lat_word_tvalid", 32'(m_axis_word_tvalid), 32'd1);
        check("lat_word_tdata",  32'(m_axis_word_tdata),  32'h1234);
        send_byte(8'h56);
        send_byte(8'h78);
        check("b2b_no_stall_cycles", 32'(cyc - t0), 32'd4);
        s_axis_byte_tvalid = 1'b0;
        drain();

        // Backpressure on the word side.
        m_axis_word_tready = 1'b0;
        exp_words.push_back(16'hABCD);
        exp_words.push_back(16'hEF01);
        send_byte(8'hAB);
        send_byte(8'hCD);
        s_axis_byte_tdata  = 8'hEF;
        s_axis_byte_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check("bp_byte_tready", 32'(s_axis_byte_tready), 32'd0);
            check("bp_word_stable", 32'(m_axis_word_tdata),  32'hABCD);
            check("bp_word_tvalid", 32'(m_axis_word_tvalid), 32'd1);
            @(posedge aclk); #1;
        end
        m_axis_word_tready = 1'b1;
        @(negedge aclk);
        check("bp_release_tready", 32'(s_axis_byte_tready), 32'd1);
        @(posedge aclk); #1;
        s_axis_byte_tvalid = 1'b0;
        check("bp_after_take_tvalid", 32'(m_axis_word_tvalid), 32'd0);
        send_byte(8'h01);
        s_axis_byte_tvalid = 1'b0;
        drain();

        // TX splitting with back-to-back words.
        tx_hs_cyc.delete();
        exp_bytes.push_back(8'hBE);
        exp_bytes.push_back(8'hEF);
        exp_bytes.push_back(8'hCA);
        exp_bytes.push_back(8'hFE);
        send_word(16'hBEEF);
        check("tx_hi_latency_tvalid", 32'(m_axis_byte_tvalid), 32'd1);
        check("tx_hi_latency_tdata",  32'(m_axis_byte_tdata),  32'hBE);
        send_word(16'hCAFE);
        s_axis_word_tvalid = 1'b0;
        drain();
        check("tx_hs_count", 32'(tx_hs_cyc.size()), 32'd4);
        if (tx_hs_cyc.size() >= 4)
            check("tx_consecutive", 32'(tx_hs_cyc[3] - tx_hs_cyc[0]), 32'd3);

        // Randomly throttled traffic in both directions.
        rand_en = 1'b1;
        fork
            while (rand_en) begin
                @(posedge aclk); #1;
                if (rand_en) begin
                    m_axis_word_tready = ($urandom_range(0, 9) < 7);
                    m_axis_byte_tready = ($urandom_range(0, 9) < 7);
                end
            end
        join_none
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    b0 = 8'($urandom);
                    b1 = 8'($urandom);
                    exp_words.push_back({b0, b1});
                    send_byte(b0);
                    send_byte(b1);
                    if ($urandom_range(0, 3) == 0) begin
                        s_axis_byte_tvalid = 1'b0;
                        idle($urandom_range(1, 3));
                    end
                end
                s_axis_byte_tvalid = 1'b0;
            end
            begin
                for (int j = 0; j < 1000; j++) begin
                    w = 16'($urandom);
                    exp_bytes.push_back(w[15:8]);
                    exp_bytes.push_back(w[7:0]);
                    send_word(w);
                    if ($urandom_range(0, 3) == 0) begin
                        s_axis_word_tvalid = 1'b0;
                        idle($urandom_range(1, 3));
                    end
                end
                s_axis_word_tvalid = 1'b0;
            end
        join
        rand_en = 1'b0;
        m_axis_word_tready = 1'b1;
        m_axis_byte_tready = 1'b1;
        drain();

        // Reset in R_HALF drops the dangling high byte.
        send_byte(8'h99);
        s_axis_byte_tvalid = 1'b0;
        areset = 1'b1;
        idle(2);
        check("midrst_byte_tready", 32'(s_axis_byte_tready), 32'd0);
        check("midrst_word_tvalid", 32'(m_axis_word_tvalid), 32'd0);
        areset = 1'b0;
        idle(3);
        check("postrst_word_tvalid", 32'(m_axis_word_tvalid), 32'd0);
        exp_words.push_back(16'h0102);
        send_byte(8'h01);
        send_byte(8'h02);
        s_axis_byte_tvalid = 1'b0;
        drain();

`ifdef AXIS_BYTE_WORD_BRIDGE_TIMEOUT_EN
        pulse_base = pulse_cnt;
        exp_words.push_back(16'h2233);
        send_byte(8'h11);
        s_axis_byte_tvalid = 1'b0;
        idle(8);
        send_byte(8'h22);
        send_byte(8'h33);
        s_axis_byte_tvalid = 1'b0;
        drain();
        check("timeout_pulse_once", 32'(pulse_cnt - pulse_base), 32'd1);

        pulse_base = pulse_cnt;
        exp_words.push_back(16'h4455);
        send_byte(8'h44);
        s_axis_byte_tvalid = 1'b0;
        idle(7);
        send_byte(8'h55);
        s_axis_byte_tvalid = 1'b0;
        drain();
        check("terminal_byte_no_pulse", 32'(pulse_cnt - pulse_base), 32'd0);
`else
        exp_words.push_back(16'h1122);
        send_byte(8'h11);
        s_axis_byte_tvalid = 1'b0;
        idle(8);
        send_byte(8'h22);
        s_axis_byte_tvalid = 1'b0;
        drain();
        check("no_timeout_pulse", 32'(pulse_cnt), 32'd0);
`endif

        idle(3);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
